// File: rtl/sram_stage_sequencer_pkg.sv
// rtl/sram_stage_sequencer_pkg.sv - shared state encoding, stage index type and timing constants
package sram_stage_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UART_RX,
        S_SEL,
        S_START,
        S_WAIT
    } state_t;

    // One second of UART silence at 50 MHz marks end of file.
    localparam int unsigned TIMEOUT_1S = 50000000;

    // Wide enough to hold NUM_STAGES itself (up to 8), which is the "all done" marker.
    localparam int STAGE_IDX_W = 4;
    typedef logic [STAGE_IDX_W-1:0] stage_idx_t;

endpackage

// File: rtl/sram_bus_mux.sv
// rtl/sram_bus_mux.sv - owner select for the single SRAM port (stages, UART, VGA)
module sram_bus_mux #(
    parameter int NUM_SRC = 5,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]          i_sel,
    input  logic [NUM_SRC*ADDR_W-1:0] i_address,
    input  logic [NUM_SRC*DATA_W-1:0] i_write_data,
    input  logic [NUM_SRC-1:0]        i_we_n,
    output logic [ADDR_W-1:0]         o_address,
    output logic [DATA_W-1:0]         o_write_data,
    output logic                      o_we_n
);

    always_comb begin
        o_address    = '0;
        o_write_data = '0;
        o_we_n       = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_address    = i_address[i*ADDR_W +: ADDR_W];
                o_write_data = i_write_data[i*DATA_W +: DATA_W];
                o_we_n       = i_we_n[i];
            end
        end
    end

endmodule

// File: rtl/sram_stage_sequencer.sv
// rtl/sram_stage_sequencer.sv - sequences decode stages after a UART file receive and arbitrates the SRAM port
module sram_stage_sequencer
    import sram_stage_sequencer_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_1S,
    parameter int TIMER_W        = 26,
    parameter int CYC_W          = 32
) (
    input  logic                         CLOCK_50_I,
    input  logic                         resetn,
    input  logic                         uart_rx_line,
    output logic                         uart_initialize,
    output logic                         uart_enable,
    input  logic [ADDR_W-1:0]            uart_address,
    input  logic [DATA_W-1:0]            uart_write_data,
    input  logic                         uart_we_n,
    input  logic [NUM_STAGES-1:0]        stage_skip,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0] stage_write_data,
    input  logic [NUM_STAGES-1:0]        stage_we_n,
    input  logic [ADDR_W-1:0]            vga_address,
    output logic                         vga_enable,
    output logic [ADDR_W-1:0]            sram_address,
    output logic [DATA_W-1:0]            sram_write_data,
    output logic                         sram_we_n,
    output logic [2:0]                   active_stage,
    output logic                         busy,
    output logic [CYC_W-1:0]             last_cycles,
    output logic [7:0]                   run_count
);

    localparam int NUM_SRC = NUM_STAGES + 2;
    localparam int SEL_W   = $clog2(NUM_SRC);

    state_t                r_state, w_next_state;
    stage_idx_t            r_idx;
    logic [TIMER_W-1:0]    r_timer;
    logic [NUM_STAGES-1:0] r_skip;
    logic [CYC_W-1:0]      r_cycles, r_last_cycles;
    logic [7:0]            r_run_count;
    logic                  r_uart_init, r_uart_en;
    logic                  w_timeout, w_all_done, w_skip_cur, w_done_cur, w_stage_owns;
    logic [SEL_W-1:0]      w_sel;

    always_comb begin
        w_skip_cur = 1'b0;
        w_done_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_idx == stage_idx_t'(i)) begin
                w_skip_cur = r_skip[i];
                w_done_cur = stage_done[i];
            end
        end
    end

    assign w_all_done   = (r_idx == stage_idx_t'(NUM_STAGES));
    assign w_timeout    = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign w_stage_owns = (r_state == S_START) || (r_state == S_WAIT);

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sel        = SEL_W'(NUM_STAGES + 1);
        stage_start  = '0;
        case (r_state)
            S_IDLE: begin
                if (!uart_rx_line) w_next_state = S_UART_RX;
            end
            S_UART_RX: begin
                w_sel = SEL_W'(NUM_STAGES);
                // A write in the same cycle means the file is still arriving.
                if (uart_we_n && w_timeout) w_next_state = S_SEL;
            end
            S_SEL: begin
                if (w_all_done)       w_next_state = S_IDLE;
                else if (!w_skip_cur) w_next_state = S_START;
            end
            S_START: begin
                w_sel = SEL_W'(r_idx);
                for (int i = 0; i < NUM_STAGES; i++) begin
                    stage_start[i] = (r_idx == stage_idx_t'(i));
                end
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_sel = SEL_W'(r_idx);
                if (w_done_cur) w_next_state = S_SEL;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_idx         <= '0;
            r_timer       <= '0;
            r_skip        <= '0;
            r_cycles      <= '0;
            r_last_cycles <= '0;
            r_run_count   <= '0;
            r_uart_init   <= 1'b0;
            r_uart_en     <= 1'b0;
        end else begin
            r_uart_init <= (r_state == S_IDLE) && !uart_rx_line;
            r_uart_en   <= r_uart_init;
            case (r_state)
                S_IDLE: r_timer <= '0;
                S_UART_RX: begin
                    if (!uart_we_n) begin
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_skip <= stage_skip;
                        r_idx  <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_SEL: begin
                    if (w_all_done)      r_run_count <= r_run_count + 8'd1;
                    else if (w_skip_cur) r_idx <= r_idx + 1'b1;
                end
                S_START: r_cycles <= CYC_W'(1);
                S_WAIT: begin
                    if (w_done_cur) begin
                        r_last_cycles <= r_cycles;
                        r_idx         <= r_idx + 1'b1;
                    end
                    if (r_cycles != '1) r_cycles <= r_cycles + 1'b1;
                end
                default: ;
            endcase
        end
    end

    sram_bus_mux #(
        .NUM_SRC (NUM_SRC),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W)
    ) u_bus_mux (
        .i_sel        (w_sel),
        .i_address    ({vga_address, uart_address, stage_address}),
        .i_write_data ({{DATA_W{1'b0}}, uart_write_data, stage_write_data}),
        .i_we_n       ({1'b1, uart_we_n, stage_we_n}),
        .o_address    (sram_address),
        .o_write_data (sram_write_data),
        .o_we_n       (sram_we_n)
    );

    assign uart_initialize = r_uart_init;
    assign uart_enable     = r_uart_en;
    assign vga_enable      = (r_state == S_IDLE);
    assign busy            = (r_state != S_IDLE);
    assign active_stage    = w_stage_owns ? r_idx[2:0] : 3'd0;
    assign last_cycles     = r_last_cycles;
    assign run_count       = r_run_count;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// tb/tb_sram_stage_sequencer.sv - scoreboard bench for the stage sequencer and SRAM arbiter
module tb_sram_stage_sequencer;

    localparam int N  = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TO = 100;
    localparam int TW = 26;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            uart_rx_line = 1'b1;
    logic            uart_initialize, uart_enable;
    logic [AW-1:0]   uart_address = '0;
    logic [DW-1:0]   uart_write_data = '0;
    logic            uart_we_n = 1'b1;
    logic [N-1:0]    stage_skip = '0;
    logic [N-1:0]    stage_start;
    logic [N-1:0]    stage_done;
    logic [N*AW-1:0] stage_address;
    logic [N*DW-1:0] stage_write_data;
    logic [N-1:0]    stage_we_n;
    logic [AW-1:0]   vga_address = '0;
    logic            vga_enable;
    logic [AW-1:0]   sram_address;
    logic [DW-1:0]   sram_write_data;
    logic            sram_we_n;
    logic [2:0]      active_stage;
    logic            busy;
    logic [CW-1:0]   last_cycles;
    logic [7:0]      run_count;

    always #10 clk = ~clk;

    sram_stage_sequencer #(
        .NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW),
        .TIMEOUT_CYCLES(TO), .TIMER_W(TW), .CYC_W(CW)
    ) dut (
        .CLOCK_50_I(clk), .resetn(resetn), .uart_rx_line(uart_rx_line),
        .uart_initialize(uart_initialize), .uart_enable(uart_enable),
        .uart_address(uart_address), .uart_write_data(uart_write_data), .uart_we_n(uart_we_n),
        .stage_skip(stage_skip), .stage_start(stage_start), .stage_done(stage_done),
        .stage_address(stage_address), .stage_write_data(stage_write_data), .stage_we_n(stage_we_n),
        .vga_address(vga_address), .vga_enable(vga_enable),
        .sram_address(sram_address), .sram_write_data(sram_write_data), .sram_we_n(sram_we_n),
        .active_stage(active_stage), .busy(busy), .last_cycles(last_cycles), .run_count(run_count)
    );

    logic [AW-1:0] st_addr[N];
    logic [DW-1:0] st_data[N];
    logic [N-1:0]  st_we = '1;
    logic [N-1:0]  bfm_done = '0;
    logic [N-1:0]  held_done = '0;
    int            delay[N];
    bit            bfm_en = 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign stage_address[g*AW +: AW]    = st_addr[g];
        assign stage_write_data[g*DW +: DW] = st_data[g];
    end
    assign stage_we_n = st_we;
    assign stage_done = bfm_done | held_done;

    int checks = 0;
    int errors = 0;
    int q_start[$];
    int q_end_runs[$];
    longint q_end_cyc[$];
    int model_runs = 0;
    longint model_last = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT fires a start or finishes a run.
    initial begin : monitor
        bit prev_busy;
        int e, r;
        longint c;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (stage_start != '0) begin
                if (q_start.size() == 0) begin
                    chk("unexpected_start", 64'(stage_start), 64'(0));
                end else begin
                    e = q_start.pop_front();
                    chk("start_onehot", 64'(stage_start), 64'(1) << e);
                    chk("start_active_stage", 64'(active_stage), 64'(e));
                    chk("start_bus_addr", 64'(sram_address), 64'(st_addr[e]));
                    chk("start_bus_data", 64'(sram_write_data), 64'(st_data[e]));
                    chk("start_bus_we", 64'(sram_we_n), 64'(st_we[e]));
                    chk("start_vga_off", 64'(vga_enable), 64'(0));
                end
            end
            if (prev_busy && !busy) begin
                if (q_end_runs.size() == 0) begin
                    chk("unexpected_end", 64'(busy), 64'(1));
                end else begin
                    r = q_end_runs.pop_front();
                    c = q_end_cyc.pop_front();
                    chk("end_run_count", 64'(run_count), 64'(r));
                    chk("end_last_cycles", 64'(last_cycles), 64'(c));
                    chk("end_vga_on", 64'(vga_enable), 64'(1));
                end
            end
            prev_busy = busy;
        end
    end

    // Stage model: raises its done for one cycle, delay[i] cycles after its start pulse.
    initial begin : stage_bfm
        int b;
        forever begin
            @(negedge clk);
            if (bfm_en && stage_start != '0) begin
                b = 0;
                for (int i = 0; i < N; i++) if (stage_start[i]) b = i;
                repeat (delay[b]) @(negedge clk);
                bfm_done[b] = 1'b1;
                @(negedge clk);
                bfm_done[b] = 1'b0;
            end
        end
    end

    task automatic randomize_bus();
        for (int i = 0; i < N; i++) begin
            st_addr[i] = AW'($urandom);
            st_data[i] = DW'($urandom);
        end
        st_we       = N'($urandom);
        vga_address = AW'($urandom);
    endtask

    task automatic plan_run(input logic [N-1:0] skip, output int lat, output bit all_skip);
        int first;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (!skip[i]) begin
                q_start.push_back(i);
                model_last = delay[i];
                if (first < 0) first = i;
            end
        end
        model_runs = (model_runs + 1) % 256;
        q_end_runs.push_back(model_runs);
        q_end_cyc.push_back(model_last);
        all_skip = (first < 0);
        lat = all_skip ? (TO + N + 1) : (TO + 1 + first);
    endtask

    task automatic drive_uart(input int nwr, input int lat, input bit all_skip);
        int cnt;
        uart_rx_line = 1'b0;
        @(negedge clk);
        uart_rx_line = 1'b1;
        chk("uart_init_pulse", 64'(uart_initialize), 64'(1));
        chk("uart_enable_early", 64'(uart_enable), 64'(0));
        chk("rx_vga_off", 64'(vga_enable), 64'(0));
        chk("rx_busy", 64'(busy), 64'(1));
        @(negedge clk);
        chk("uart_init_cleared", 64'(uart_initialize), 64'(0));
        chk("uart_enable_pulse", 64'(uart_enable), 64'(1));
        for (int k = 0; k < nwr; k++) begin
            if (k > 0) @(negedge clk);
            uart_address    = AW'(k);
            uart_write_data = DW'($urandom);
            uart_we_n       = 1'b0;
            #1;
            chk("uart_bus_we", 64'(sram_we_n), 64'(0));
            chk("uart_bus_addr", 64'(sram_address), 64'(k));
            chk("uart_bus_data", 64'(sram_write_data), 64'(uart_write_data));
        end
        @(negedge clk);
        uart_we_n = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (cnt < 1000 && (all_skip ? busy : (stage_start == '0)));
        chk("timeout_latency", 64'(cnt), 64'(lat));
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (busy && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        chk("run_finishes", 64'(busy), 64'(0));
        chk("idle_bus_addr", 64'(sram_address), 64'(vga_address));
        chk("idle_bus_we", 64'(sram_we_n), 64'(1));
        @(negedge clk);
    endtask

    task automatic new_run(input logic [N-1:0] skip, input int nwr);
        int lat;
        bit all_skip;
        randomize_bus();
        stage_skip = skip;
        plan_run(skip, lat, all_skip);
        drive_uart(nwr, lat, all_skip);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_uart_init"}, 64'(uart_initialize), 64'(0));
        chk({tag, "_uart_enable"}, 64'(uart_enable), 64'(0));
        chk({tag, "_stage_start"}, 64'(stage_start), 64'(0));
        chk({tag, "_active_stage"}, 64'(active_stage), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_vga_enable"}, 64'(vga_enable), 64'(1));
        chk({tag, "_last_cycles"}, 64'(last_cycles), 64'(0));
        chk({tag, "_run_count"}, 64'(run_count), 64'(0));
        chk({tag, "_bus_addr"}, 64'(sram_address), 64'(vga_address));
        chk({tag, "_bus_data"}, 64'(sram_write_data), 64'(0));
        chk({tag, "_bus_we"}, 64'(sram_we_n), 64'(1));
    endtask

    initial begin : stimulus
        int cnt, lat;
        randomize_bus();
        delay = '{10, 20, 5};
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);

        delay = '{10, 20, 5};
        new_run(3'b000, 4);

        for (int i = 0; i < N; i++) delay[i] = $urandom_range(1, 30);
        new_run(3'b010, 2);

        new_run(3'b111, 1);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) delay[i] = $urandom_range(1, 30);
            new_run(N'($urandom_range(0, 7)), $urandom_range(1, 4));
        end

        // Stage 0 done held high across its start pulse; stage 2 done high but not owning.
        bfm_en    = 1'b0;
        held_done = 3'b101;
        delay[0]  = 1;
        new_run(3'b110, 1);
        held_done = '0;
        bfm_en    = 1'b1;

        // Reset during stage 1's wait: starts 0 and 1 seen, then reset values.
        delay = '{3, 40, 5};
        randomize_bus();
        stage_skip = '0;
        q_start.push_back(0);
        q_start.push_back(1);
        q_end_runs.push_back(0);
        q_end_cyc.push_back(0);
        model_runs = 0;
        model_last = 0;
        lat = TO + 1;
        drive_uart(1, lat, 1'b0);
        cnt = 0;
        while (!stage_start[1] && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        chk("stage1_started", 64'(stage_start[1]), 64'(1));
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        chk("start_queue_drained", 64'(q_start.size()), 64'(0));
        chk("end_queue_drained", 64'(q_end_runs.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_stage_sequencer.md
Name: sram_stage_sequencer

Overview:
- Top-level sequencer and SRAM bus arbiter for the decoder datapath.
- After a UART file receive, it runs NUM_STAGES decode stages (M1, M2, M3, ...) in order, using a start-pulse/done handshake per stage.
- It grants the single SRAM port to exactly one owner: UART, the active stage, or VGA.
- Stages can be skipped per run, and per-stage cycle counts are captured for profiling.

Parameters:
- NUM_STAGES, 3, number of decode stages sequenced after UART receive (1..8)
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- TIMEOUT_CYCLES, 50000000, UART idle cycles marking end of file (1 s at 50 MHz)
- TIMER_W, 26, UART timeout counter width; must hold TIMEOUT_CYCLES-1
- CYC_W, 32, per-stage cycle counter width

Ports:
- CLOCK_50_I  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- uart_rx_line  in  1  raw UART RX pin; idle high
- uart_initialize  out  1  one-cycle init pulse to the UART-SRAM interface
- uart_enable  out  1  one-cycle enable, the cycle after uart_initialize
- uart_address  in  ADDR_W  UART write address
- uart_write_data  in  DATA_W  UART write data
- uart_we_n  in  1  UART write strobe, active low
- stage_skip  in  NUM_STAGES  bit i=1 skips stage i; sampled on leaving S_UART_RX
- stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse
- stage_done  in  NUM_STAGES  stage completion; level or pulse
- stage_address  in  NUM_STAGES*ADDR_W  flattened; stage i at [i*ADDR_W +: ADDR_W]
- stage_write_data  in  NUM_STAGES*DATA_W  flattened, same packing
- stage_we_n  in  NUM_STAGES  per-stage write strobe, active low
- vga_address  in  ADDR_W  VGA read address
- vga_enable  out  1  VGA fetch enable
- sram_address  out  ADDR_W  to SRAM controller
- sram_write_data  out  DATA_W  to SRAM controller
- sram_we_n  out  1  to SRAM controller
- active_stage  out  3  index of the stage owning the bus; 0 when no stage owns it
- busy  out  1  high in any state other than S_IDLE
- last_cycles  out  CYC_W  cycle count of the most recently completed stage
- run_count  out  8  completed full runs; wraps at 255 to 0

Behaviour:
- Reset values (asynchronous): state=S_IDLE; vga_enable=1; all other outputs 0 (uart_initialize, uart_enable, stage_start, active_stage, last_cycles, run_count, busy); UART timer 0; skip register 0.
- S_IDLE:
  - vga_enable=1.
  - When uart_rx_line=0: uart_initialize<=1, timer<=0, vga_enable<=0, go to S_UART_RX.
- S_UART_RX:
  - uart_initialize cleared after 1 cycle; uart_enable pulses 1 cycle, the cycle after the init pulse.
  - timer increments every cycle and clears whenever uart_we_n=0.
  - When timer==TIMEOUT_CYCLES-1: latch stage_skip, set i=0, go to S_SEL.
- S_SEL (1 cycle):
  - If i==NUM_STAGES: run_count++ and go to S_IDLE.
  - Else if skip[i]: i++ and stay in S_SEL.
  - Else go to S_START.
- S_START (1 cycle): stage_start[i]=1; cycle counter <= 1; go to S_WAIT.
- S_WAIT:
  - cycle counter increments (saturates at all-ones).
  - On stage_done[i]=1: last_cycles<=counter, i++, go to S_SEL.
  - stage_done[i] is ignored in S_START, so a done held high from a previous run cannot end the new run early.
  - Done bits of other stages are ignored.
- SRAM mux (combinational, registered state only):
  - S_UART_RX: bus driven by uart_address, uart_write_data, uart_we_n.
  - S_START and S_WAIT: bus driven by stage i; active_stage=i.
  - All other states: address=vga_address, write data=0, we_n=1.
- uart_rx_line is ignored outside S_IDLE.
- vga_enable=0 in every state except S_IDLE.
- All stages skipped: S_UART_RX -> S_SEL x(NUM_STAGES+1) -> S_IDLE; run_count still increments.
- resetn low mid-run: immediate return to S_IDLE; stage_start drops the same instant. Stages are expected to share resetn.
- Latency from UART timeout to stage_start[first unskipped stage] = 2 + (number of skipped stages preceding it) cycles.

Decomposition:
- Shared package holds: the state enum (S_IDLE, S_UART_RX, S_SEL, S_START, S_WAIT), the 1 s timeout constant, and the stage index type. The existing top_state_type is retired in favour of this enum.
- One natural sub-module: sram_bus_mux, the parametrised N+2 input owner select for address, write data and we_n.

Test Plan:
- Reset, then uart_rx_line=0 for 1 cycle -> uart_initialize=1 next cycle, uart_enable=1 the cycle after, vga_enable=0, sram_we_n follows uart_we_n.
- 4 UART writes at address 0..3, then idle with TIMEOUT_CYCLES=100 -> stage_start=3'b001 exactly 101 cycles after the last write strobe, one cycle wide.
- Stages 0/1/2 assert done after 10/20/5 cycles -> starts fire in order, last_cycles=5 at end, run_count=1, return to S_IDLE, vga_enable=1.
- stage_skip=3'b010 -> stage_start never shows bit 1; bus owned by stage 2 right after stage 0 completes.
- stage_done[0] held at 1 across the start pulse -> no completion in S_START, completion on the next cycle; stage_done[2]=1 while stage 0 is active -> ignored.
- resetn dropped during S_WAIT of stage 1 -> all outputs at reset values immediately; sram_address=vga_address, sram_we_n=1.
